// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM read port among N_REQ pixel fetchers.
// An optional per-requester lock keeps the port for up to MAX_BURST grants.
// A tag pipeline tracks ROM latency so each pixel returns with its requester id.
module sprite_rom_arbiter #(
   parameter int unsigned N_REQ     = 4,
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned ROM_LAT   = 2,
   parameter int unsigned MAX_BURST = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ-1:0]           lock,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   output logic [N_REQ-1:0]           gnt,
   output logic [ADDR_W-1:0]          rom_addr,
   input  logic [DATA_W-1:0]          rom_data,
   output logic                       rsp_valid,
   output logic [$clog2(N_REQ)-1:0]   rsp_id,
   output logic [DATA_W-1:0]          rsp_data
);

   localparam int unsigned ID_W  = $clog2(N_REQ);
   localparam int unsigned CNT_W = 8;
   localparam int unsigned NSTG  = ROM_LAT + 1;

   typedef enum logic {IDLE, LOCKED} mode_t;

   mode_t                       mode, mode_n;
   logic [ID_W-1:0]             ptr, ptr_n;
   logic [ID_W-1:0]             owner, owner_n;
   logic [CNT_W-1:0]            cnt, cnt_n;
   logic [NSTG-1:0]             tag_v;
   logic [NSTG-1:0][ID_W-1:0]   tag_id;

   logic                        keep;
   logic                        gnt_any;
   logic [ID_W-1:0]             gnt_idx;
   int unsigned                 j;

   // Grant selection: locked owner keeps the port, otherwise round-robin from ptr.
   // After a locked grant ptr already points at owner+1, so release searches others first.
   always_comb begin
      keep    = 1'b0;
      gnt_any = 1'b0;
      gnt_idx = '0;
      j       = 0;
      gnt     = '0;
      mode_n  = mode;
      owner_n = owner;
      cnt_n   = cnt;
      ptr_n   = ptr;

      keep = (mode == LOCKED) && req[owner] && lock[owner] &&
             (cnt < CNT_W'(MAX_BURST));

      if (keep) begin
         gnt_any = 1'b1;
         gnt_idx = owner;
      end else begin
         for (int unsigned k = 0; k < N_REQ; k++) begin
            j = 32'(ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
            if (!gnt_any && req[j]) begin
               gnt_any = 1'b1;
               gnt_idx = ID_W'(j);
            end
         end
      end

      if (gnt_any) begin
         gnt[gnt_idx] = 1'b1;
         ptr_n = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
         if (keep) begin
            cnt_n = cnt + CNT_W'(1);
         end else if (lock[gnt_idx]) begin
            mode_n  = LOCKED;
            owner_n = gnt_idx;
            cnt_n   = CNT_W'(1);
         end else begin
            mode_n = IDLE;
         end
      end else begin
         mode_n = IDLE;
      end
   end

   // Arbitration state, ROM address, tag pipeline and response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode      <= IDLE;
         ptr       <= '0;
         owner     <= '0;
         cnt       <= '0;
         tag_v     <= '0;
         tag_id    <= '0;
         rom_addr  <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         mode  <= mode_n;
         ptr   <= ptr_n;
         owner <= owner_n;
         cnt   <= cnt_n;

         if (gnt_any) rom_addr <= req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];

         tag_v[0]  <= gnt_any;
         tag_id[0] <= gnt_idx;
         for (int unsigned s = 1; s < NSTG; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end

         rsp_valid <= tag_v[ROM_LAT];
         rsp_id    <= tag_id[ROM_LAT];
         if (tag_v[ROM_LAT]) rsp_data <= rom_data;
      end
   end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: reset, single fetch, fairness, lock cap,
// early release and reset while fetches are in flight.
module tb_sprite_rom_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 19;
   localparam int unsigned DW = 16;
   localparam int unsigned IW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req, lock, gnt;
   logic [N*AW-1:0]   req_addr;
   logic [AW-1:0]     rom_addr;
   logic [DW-1:0]     rom_data, rom_r1;
   logic              rsp_valid;
   logic [IW-1:0]     rsp_id;
   logic [DW-1:0]     rsp_data;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   int           g_id[$], g_cyc[$], r_id[$], r_cyc[$], exp_q[$];
   logic [15:0]  r_dat[$];

   sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(19), .DATA_W(16), .ROM_LAT(2), .MAX_BURST(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .lock      (lock),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   always #5 clk = ~clk;

   // ROM model: synchronous read plus output register, data = addr[15:0] ^ A5A5
   always @(posedge clk) begin
      rom_r1   <= rom_addr[15:0] ^ 16'hA5A5;
      rom_data <= rom_r1;
   end

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int oh_idx(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   // Log grants and responses mid-cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (|gnt) begin
            g_id.push_back(oh_idx(gnt));
            g_cyc.push_back(cyc);
         end
         if (rsp_valid) begin
            r_id.push_back(int'(rsp_id));
            r_cyc.push_back(cyc);
            r_dat.push_back(rsp_data);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic flush(input int n);
      repeat (n) step();
   endtask

   task automatic clear_logs();
      g_id.delete(); g_cyc.delete(); r_id.delete(); r_cyc.delete(); r_dat.delete(); exp_q.delete();
   endtask

   task automatic set_addr(input int i, input logic [AW-1:0] a);
      req_addr[i*AW +: AW] = a;
   endtask

   function automatic logic [15:0] exp_data(input int id);
      logic [AW-1:0] a;
      a = req_addr[id*AW +: AW];
      return a[15:0] ^ 16'hA5A5;
   endfunction

   // Compare logged grants and responses against exp_q
   task automatic check_log(input string tag);
      check({tag, "_ngnt"}, 32'(g_id.size()), 32'(exp_q.size()));
      check({tag, "_nrsp"}, 32'(r_id.size()), 32'(exp_q.size()));
      for (int k = 0; k < exp_q.size(); k++) begin
         if (k < g_id.size()) check($sformatf("%s_gid%0d", tag, k), 32'(g_id[k]), 32'(exp_q[k]));
         if (k < r_id.size()) begin
            check($sformatf("%s_rid%0d", tag, k), 32'(r_id[k]), 32'(exp_q[k]));
            check($sformatf("%s_rdat%0d", tag, k), 32'(r_dat[k]), 32'(exp_data(exp_q[k])));
            if (k < g_cyc.size())
               check($sformatf("%s_lat%0d", tag, k), 32'(r_cyc[k] - g_cyc[k]), 32'd4);
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 4'b1111;
      lock  = 4'b0000;
      for (int i = 0; i < N; i++) set_addr(i, AW'(100 + i));

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'h1);
      check("rst_rom_addr", 32'(rom_addr), 32'h0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_rsp_data", 32'(rsp_data), 32'h0);

      // First grant right after release goes to requester 0
      rst_n = 1'b1;
      #1;
      check("first_gnt", 32'(gnt), 32'h1);
      step();
      req = 4'b0000;
      flush(6);
      exp_q = '{0};
      check_log("first");
      clear_logs();

      // Single request, ptr now 1
      set_addr(2, 19'd450);
      req = 4'b0100;
      #1;
      check("single_gnt", 32'(gnt), 32'h4);
      step();
      req = 4'b0000;
      check("single_rom_addr", 32'(rom_addr), 32'd450);
      step();
      step();
      check("single_early", 32'(rsp_valid), 32'h0);
      step();
      check("single_valid", 32'(rsp_valid), 32'h1);
      check("single_id", 32'(rsp_id), 32'h2);
      check("single_data", 32'(rsp_data), 32'hA467);
      step();
      check("single_done", 32'(rsp_valid), 32'h0);
      check("single_hold", 32'(rsp_data), 32'hA467);
      set_addr(2, 19'd102);
      flush(2);
      clear_logs();

      // Fairness: grant 3 first so ptr wraps to 0, then all request for 8 cycles
      req = 4'b1000;
      #1;
      check("fair_pre", 32'(gnt), 32'h8);
      step();
      req = 4'b1111;
      for (int c = 0; c < 8; c++) begin
         #1;
         check($sformatf("fair_gnt%0d", c), 32'(gnt), 32'(1 << (c % 4)));
         step();
      end
      req = 4'b0000;
      flush(6);
      exp_q = '{3, 0, 1, 2, 3, 0, 1, 2, 3};
      check_log("fair");
      clear_logs();

      // Lock cap: 0 locked for 8 grants, then 1, then 0 again for 8
      req  = 4'b0011;
      lock = 4'b0001;
      for (int c = 0; c < 17; c++) begin
         #1;
         check($sformatf("lock_gnt%0d", c), 32'(gnt), (c == 8) ? 32'h2 : 32'h1);
         step();
      end
      req  = 4'b0000;
      lock = 4'b0000;
      flush(6);
      exp_q = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      check_log("lock");
      clear_logs();

      // Early release: owner 0 drops req, 3 wins in the same cycle
      req  = 4'b0001;
      lock = 4'b0001;
      #1;
      check("early_g0", 32'(gnt), 32'h1);
      step();
      req = 4'b1001;
      for (int c = 1; c < 3; c++) begin
         #1;
         check($sformatf("early_g%0d", c), 32'(gnt), 32'h1);
         step();
      end
      req = 4'b1000;
      #1;
      check("early_rel", 32'(gnt), 32'h8);
      step();
      req  = 4'b0000;
      lock = 4'b0000;
      #1;
      check("early_idle", 32'(gnt), 32'h0);
      flush(6);
      exp_q = '{0, 0, 0, 3};
      check_log("early");
      if (g_cyc.size() >= 4) check("early_nogap", 32'(g_cyc[3] - g_cyc[2]), 32'd1);
      clear_logs();

      // Reset while two fetches are in flight
      req = 4'b0011;
      #1;
      check("mid_g0", 32'(gnt), 32'h1);
      step();
      #1;
      check("mid_g1", 32'(gnt), 32'h2);
      step();
      req = 4'b0000;
      step();
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", 32'(gnt), 32'h0);
      check("mid_rst_rom_addr", 32'(rom_addr), 32'h0);
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_id", 32'(rsp_id), 32'h0);
      check("mid_rst_data", 32'(rsp_data), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      req   = 4'b1111;
      #1;
      check("mid_ptr_reset", 32'(gnt), 32'h1);
      req = 4'b0000;
      flush(8);
      check("mid_no_rsp", 32'(r_id.size()), 32'd0);
      check("mid_rom_addr", 32'(rom_addr), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares one single-port RGBA sprite ROM read port among up to N_REQ requesters (mole, hammer, score and background pixel fetchers). It accepts per-requester pixel addresses through a req/gnt handshake and drives the ROM address. It tracks the fixed ROM read latency with a tag pipeline and returns each 16-bit RGBA word tagged with the requester index. An optional per-requester lock keeps the port for consecutive scanline fetches, capped at MAX_BURST grants.

## Interface
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 19, ROM address width
- DATA_W, 16, pixel width, R[15:12] G[11:8] B[7:4] A[3:0]
- ROM_LAT, 2, cycles from rom_addr change to matching rom_data (ROM plus its output register)
- MAX_BURST, 8, max consecutive locked grants to one owner (1..255)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- req  in  N_REQ  request per requester; held with addr until granted
- lock  in  N_REQ  request to keep grant on following cycles
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
- gnt  out  N_REQ  one-hot grant, combinational from req, lock and registered state; transfer = req[i] & gnt[i]
- rom_addr  out  ADDR_W  registered ROM address
- rom_data  in  DATA_W  ROM read data
- rsp_valid  out  1  registered response strobe, one cycle per accepted request
- rsp_id  out  $clog2(N_REQ)  requester index of the response
- rsp_data  out  DATA_W  registered pixel word

## Operation
- State: ptr (RR start index), mode IDLE/LOCKED, owner, cnt (8-bit burst count), and tag pipeline of ROM_LAT+1 stages, each {valid, id}.
- IDLE: gnt is the first i with req[i]=1 searching ptr, ptr+1, … mod N_REQ. gnt=0 if req=0.
- On any grant to i: ptr <= (i+1) mod N_REQ.
- The grant with lock[i]=1 moves to LOCKED: owner=i, cnt=1. Without lock, the block stays in or returns to IDLE.
- LOCKED: if req[owner] & lock[owner] & cnt<MAX_BURST, then gnt=owner and cnt++.
  - Otherwise the owner is released in the same cycle. IDLE RR search runs, starting at owner+1, so others win first.
  - The owner may win again only if no other requester is active. A fresh locked grant restarts cnt=1.
- The owner dropping req or lock releases it the same cycle. No idle bubble.
- Each grant to i:
  - rom_addr <= req_addr[i] at the next edge.
  - Tag stage 0 <= {1, i}. The tag shifts each cycle.
- No grant: rom_addr holds its value and stage 0 <= {0, x}.
- Final tag stage aligned to rom_data:
  - rsp_valid <= tag.valid; rsp_id <= tag.id.
  - rsp_data <= rom_data when valid, otherwise holds.
- Responses return strictly in grant order. There is no backpressure, so consumers must sink every rsp_valid.
- Reset values: ptr=0, IDLE, owner=0, cnt=0, all tag valids 0, rom_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0. gnt evaluates from these (owner-less IDLE).

## Timing
- Grant in cycle T.
- rom_addr valid in T+1.
- rom_data valid in T+1+ROM_LAT.
- rsp_valid, rsp_id and rsp_data valid in T+2+ROM_LAT, which is 4 cycles at the default.
- Throughput is one grant per cycle. Back-to-back grants give back-to-back rsp_valid.
- Reset assertion mid-operation clears in-flight tags immediately. No response for requests granted before reset is ever emitted.
- The first grant is possible in the first cycle after rst_n deasserts.
- cnt never exceeds MAX_BURST. MAX_BURST=1 makes lock a no-op.
- ptr wraps from N_REQ-1 to 0.

## Test plan
- Reset: hold rst_n=0 with req=4'b1111.
  - Required: gnt=4'b0001, rom_addr=0, rsp_valid=0.
  - After release, the first grant goes to requester 0.
- Single request: req=4'b0100, addr2=19'd450, ROM model data=addr[15:0]^16'hA5A5.
  - Required: gnt=4'b0100 at T, rom_addr=450 at T+1.
  - Required: rsp_valid=1, rsp_id=2, rsp_data=16'hA467 at T+4.
- Fairness: req=4'b1111 held for 8 cycles, no lock.
  - Required grant order: 0,1,2,3,0,1,2,3.
  - Required: 8 responses, ids in the same order, 4 cycles later.
- Lock cap: req=4'b0011, lock=4'b0001 held.
  - Required grants: 0 ×8, then 1, then 0 ×8 with cnt restarting.
  - Required: rsp_id sequence matches.
- Early release: requester 0 locked.
  - Drop req[0] after 3 grants with req[3]=1.
  - Required: grant to 3 in the same cycle req[0] falls, no gap cycle.
- Reset mid-flight: grant 2 requests, then pulse rst_n low for 1 cycle before responses.
  - Required: no rsp_valid ever appears for them, and all outputs return to reset values.
